data_write_buffer: RTL
======================

// Module: data_write_buffer
// PURPOSE
//  Store write buffer between the core data SRAM-like port and the AXI transfer bridge data port.
//  Retires stores to the core at once and drains them in order to the bridge.
//  Loads go to the bridge one at a time. The instruction path does not pass through this block.
// PARAMETERS
//  DEPTH  4   store FIFO entries; power of two, >=2
//  AW     32  address width
//  DW     32  data width
// PORTS
//  clk         in   1   single clock
//  reset       in   1   synchronous, active-high
//  up_req      in   1   core request valid
//  up_wr       in   1   1=store 0=load
//  up_size     in   2   0/1/2 = byte/half/word
//  up_wstrb    in   4   byte enables (store)
//  up_addr     in   AW  address
//  up_wdata    in   DW  store data
//  up_addr_ok  out  1   request accepted this cycle
//  up_data_ok  out  1   response pulse, one per accepted request, in order
//  up_rdata    out  DW  load data, valid with up_data_ok
//  dn_req/dn_wr/dn_size/dn_wstrb/dn_addr/dn_wdata  out  1/1/2/4/AW/DW  request to bridge
//  dn_addr_ok  in   1   bridge accepted dn request
//  dn_data_ok  in   1   bridge response (read data or write ack)
//  dn_rdata    in   DW  bridge read data
// BEHAVIOUR
//  Reset: up_addr_ok=0, up_data_ok=0, dn_req=0, FIFO empty, ld_pend=0, FSM=D_IDLE.
//  Reset mid-operation discards buffered stores and outstanding transactions.
//  Handshake: a transfer occurs when req&addr_ok are high in the same cycle. addr_ok is combinational from state and req.
//  Store accept: up_addr_ok = up_req & up_wr & !full & !ld_pend. The entry {addr,size,wstrb,wdata} is pushed.
//    up_data_ok pulses on the next cycle (registered), 1-cycle latency.
//  Load accept: only in D_IDLE with ld_ok. dn_req=1 with up_* fields passed through; up_addr_ok=dn_addr_ok.
//    On accept: ld_pend=1, FSM goes to D_RD_RESP. up_data_ok=dn_data_ok and up_rdata=dn_rdata (combinational).
//    ld_pend clears on dn_data_ok.
//  No new up request (load or store) is accepted while ld_pend=1, so responses stay in order.
//    A store data_ok (t+1) never collides with a load data_ok (>= t+2).
//  FSM (one downstream transaction outstanding at a time):
//    D_IDLE    -> D_RD_RESP on load accept (load has priority over drain).
//              -> D_WR_RESP when FIFO non-empty, no load requesting, and dn_addr_ok for the head entry.
//                 The head is popped on the dn_addr_ok cycle.
//    D_WR_RESP -> D_IDLE on dn_data_ok.
//    D_RD_RESP -> D_IDLE on dn_data_ok.
//  dn_req in D_IDLE = (load requesting & ld_ok) | (!empty & !load requesting). dn_req=0 in RESP states.
//  Full: store stalls (up_addr_ok=0) until a pop. A push and a pop in the same cycle are allowed when full.
//  Pointer wrap: log2(DEPTH)+1-bit pointers. full when MSBs differ and the rest are equal; empty when all bits are equal.
//  Hazard: a load matches when any valid FIFO entry has addr[AW-1:2]==up_addr[AW-1:2]. The pushing-this-cycle entry is not yet counted.
// CONFIGURATION
//  WBUF_BYPASS_EN defined: ld_ok = !match & (FIFO non-empty state allowed). Non-conflicting loads overtake buffered stores.
//    A conflicting load waits until every matching entry has drained and its D_WR_RESP has completed.
//  WBUF_BYPASS_EN undefined: ld_ok = empty & FSM==D_IDLE. Every load waits for a full drain; no comparators are built.
// STRUCTURE
//  Shared header wbuf_defs.vh: FSM state encodings (D_IDLE, D_WR_RESP, D_RD_RESP) and FIFO entry width.
//    Entry width = AW+2+4+DW.
//  Sub-module wbuf_fifo: synchronous FIFO with push, pop, full, empty, head output, and per-entry word-address match vector.
//    The match vector is generated only under WBUF_BYPASS_EN.
// TESTING
//  1. Store word 0x1000 data 0xAABBCCDD, bridge acks after 5 cycles.
//     -> up_addr_ok same cycle, up_data_ok next cycle.
//     -> dn write to 0x1000 with wstrb 4'hF one cycle later.
//  2. Five back-to-back stores, DEPTH=4, bridge holds dn_addr_ok=0.
//     -> 4 accepted; 5th stalls until the first pop.
//     -> dn writes issued in order.
//  3. Store 0x2000, then load 0x3000 with the bridge stalled on the write.
//     -> bypass: load issued before the drain resumes, rdata correct.
//     -> no bypass: load waits until the FIFO is empty.
//  4. Store byte 0x2001, then load word 0x2000.
//     -> load issued only after the store's dn_data_ok; returns the merged data from the bridge memory model.
//  5. Load outstanding, core raises a store.
//     -> up_addr_ok=0 until the load's up_data_ok, then the store is accepted the next cycle.
//  6. reset asserted with 3 entries buffered and D_WR_RESP active.
//     -> next cycle: dn_req=0, up_data_ok=0, FIFO empty, FSM=D_IDLE.

Source files
------------

// File: rtl/data_write_buffer_pkg.sv
// Shared types for the data write buffer: downstream FSM states and FIFO entry layout.
package data_write_buffer_pkg;

    typedef enum logic [1:0] {
        DIdle   = 2'd0,
        DWrResp = 2'd1,
        DRdResp = 2'd2
    } dstate_e;

    localparam int unsigned SizeW = 2;
    localparam int unsigned StrbW = 4;

    // Entry packing is {addr, size, wstrb, wdata}.
    function automatic int unsigned entry_width(input int unsigned aw, input int unsigned dw);
        return aw + SizeW + StrbW + dw;
    endfunction

endpackage

// File: rtl/data_write_buffer_fifo.sv
// Store FIFO for the write buffer. With WBUF_BYPASS_EN defined it also exposes a
// per-entry word-address match vector used for load hazard detection.
module data_write_buffer_fifo
    import data_write_buffer_pkg::*;
#(
    parameter int unsigned Depth = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32,
    localparam int unsigned EW   = entry_width(AW, DW)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [EW-1:0]     push_entry_i,
    output logic [EW-1:0]     head_o,
    output logic              full_o,
    output logic              empty_o
`ifdef WBUF_BYPASS_EN
    ,
    input  logic [AW-3:0]     match_waddr_i,
    output logic [Depth-1:0]  match_o
`endif
);

    localparam int unsigned IdxW = $clog2(Depth);
    localparam int unsigned PtrW = IdxW + 1;

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]   mem_q [Depth];
    logic [EW-1:0]   mem_d [Depth];

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                     (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
    assign head_o  = mem_q[rd_ptr_q[IdxW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_i) begin
            mem_d[wr_ptr_q[IdxW-1:0]] = push_entry_i;
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
        mem_q <= mem_d;
    end

`ifdef WBUF_BYPASS_EN
    logic [PtrW-1:0] count;
    assign count = wr_ptr_q - rd_ptr_q;

    // An entry is live when its distance from the read pointer is below the fill count.
    for (genvar i = 0; i < Depth; i++) begin : g_match
        logic [IdxW-1:0] off;
        assign off        = IdxW'(i) - rd_ptr_q[IdxW-1:0];
        assign match_o[i] = ({1'b0, off} < count) &&
                            (mem_q[i][EW-1 -: AW-2] == match_waddr_i);
    end
`endif

endmodule

// File: rtl/data_write_buffer.sv
// Store write buffer between the core data port and the bridge data port.
// Define WBUF_BYPASS_EN to let non-conflicting loads overtake buffered stores.
module data_write_buffer
    import data_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          up_req,
    input  logic          up_wr,
    input  logic [1:0]    up_size,
    input  logic [3:0]    up_wstrb,
    input  logic [AW-1:0] up_addr,
    input  logic [DW-1:0] up_wdata,
    output logic          up_addr_ok,
    output logic          up_data_ok,
    output logic [DW-1:0] up_rdata,
    output logic          dn_req,
    output logic          dn_wr,
    output logic [1:0]    dn_size,
    output logic [3:0]    dn_wstrb,
    output logic [AW-1:0] dn_addr,
    output logic [DW-1:0] dn_wdata,
    input  logic          dn_addr_ok,
    input  logic          dn_data_ok,
    input  logic [DW-1:0] dn_rdata
);

    localparam int unsigned EW = entry_width(AW, DW);

    dstate_e st_q, st_d;
    logic    ld_pend_q, ld_pend_d;
    logic    st_ack_q, st_ack_d;

    logic          full, empty, push, pop;
    logic          load_req, ld_ok, ld_go;
    logic [EW-1:0] head;
    logic [AW-1:0] head_addr;
    logic [1:0]    head_size;
    logic [3:0]    head_strb;
    logic [DW-1:0] head_wdata;

    assign {head_addr, head_size, head_strb, head_wdata} = head;

    assign load_req = up_req & ~up_wr;

`ifdef WBUF_BYPASS_EN
    logic [DEPTH-1:0] match;
    assign ld_ok = ~|match;
`else
    assign ld_ok = empty;
`endif

    // A blocked load must not hold off the drain, otherwise it would wait forever.
    assign ld_go = load_req & ld_ok & ~ld_pend_q & (st_q == DIdle);
    assign pop   = (st_q == DIdle) & ~ld_go & ~empty & dn_addr_ok;
    assign push  = up_req & up_wr & ~ld_pend_q & (~full | pop);

    data_write_buffer_fifo #(
        .Depth (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push_i        (push),
        .pop_i         (pop),
        .push_entry_i  ({up_addr, up_size, up_wstrb, up_wdata}),
        .head_o        (head),
        .full_o        (full),
        .empty_o       (empty)
`ifdef WBUF_BYPASS_EN
        ,
        .match_waddr_i (up_addr[AW-1:2]),
        .match_o       (match)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q      <= DIdle;
            ld_pend_q <= 1'b0;
            st_ack_q  <= 1'b0;
        end else begin
            st_q      <= st_d;
            ld_pend_q <= ld_pend_d;
            st_ack_q  <= st_ack_d;
        end
    end

    always_comb begin
        st_d      = st_q;
        ld_pend_d = ld_pend_q;
        st_ack_d  = push;
        unique case (st_q)
            DIdle: begin
                if (ld_go && dn_addr_ok) begin
                    st_d      = DRdResp;
                    ld_pend_d = 1'b1;
                end else if (pop) begin
                    st_d = DWrResp;
                end
            end
            DWrResp: begin
                if (dn_data_ok) st_d = DIdle;
            end
            DRdResp: begin
                if (dn_data_ok) begin
                    st_d      = DIdle;
                    ld_pend_d = 1'b0;
                end
            end
            default: st_d = DIdle;
        endcase
    end

    always_comb begin
        dn_req   = 1'b0;
        dn_wr    = 1'b1;
        dn_size  = head_size;
        dn_wstrb = head_strb;
        dn_addr  = head_addr;
        dn_wdata = head_wdata;
        if (ld_go) begin
            dn_req   = 1'b1;
            dn_wr    = 1'b0;
            dn_size  = up_size;
            dn_wstrb = up_wstrb;
            dn_addr  = up_addr;
            dn_wdata = up_wdata;
        end else if ((st_q == DIdle) && !empty) begin
            dn_req = 1'b1;
        end
        up_addr_ok = push | (ld_go & dn_addr_ok);
        up_data_ok = st_ack_q | ((st_q == DRdResp) & dn_data_ok);
    end

    assign up_rdata = dn_rdata;

endmodule
